// File: rtl/square_finder_pkg.sv
// Shared constants for the iterative squarer: state encoding and default operand width.
package square_finder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [1:0] state_idle = 2'b00;
    localparam logic [1:0] state_run  = 2'b01;
    localparam logic [1:0] state_done = 2'b10;

endpackage

// File: rtl/square_finder_if.sv
// Start/busy/done handshake bundle between a requester and the squarer.
interface square_finder_if #(
    parameter int unsigned WIDTH = square_finder_pkg::DEFAULT_WIDTH
);

    logic                 start;
    logic [WIDTH-1:0]     root;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   square;

    modport master (
        output start,
        output root,
        input  busy,
        input  done,
        input  square
    );

    modport slave (
        input  start,
        input  root,
        output busy,
        output done,
        output square
    );

endinterface

// File: rtl/square_path_data.sv
// Datapath for the squarer: accumulates successive odd numbers until count reaches the operand.
module square_path_data #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_action_load,
    input  logic                 i_action_step,
    input  logic                 i_action_store,
    input  logic [WIDTH-1:0]     i_root,
    output logic                 o_flag_equal,
    output logic [2*WIDTH-1:0]   o_square
);

    logic [WIDTH-1:0]   r_operand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_delta;
    logic [WIDTH-1:0]   r_count;
    logic [2*WIDTH-1:0] r_square;

    // delta carries one extra bit so the final +2 after 2N-1 cannot wrap
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_operand <= '0;
            r_acc     <= '0;
            r_delta   <= '0;
            r_count   <= '0;
            r_square  <= '0;
        end else begin
            if (i_action_load) begin
                r_operand <= i_root;
                r_acc     <= '0;
                r_delta   <= {{WIDTH{1'b0}}, 1'b1};
                r_count   <= '0;
            end
            if (i_action_step) begin
                r_acc   <= r_acc + {{(WIDTH-1){1'b0}}, r_delta};
                r_delta <= r_delta + {{(WIDTH-1){1'b0}}, 2'd2};
                r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (i_action_store) begin
                r_square <= r_acc;
            end
        end
    end

    assign o_flag_equal = (r_count == r_operand);
    assign o_square     = r_square;

endmodule

// File: rtl/square_finder.sv
// Iterative integer squarer: control FSM driving the odd-number summing datapath.
module square_finder
    import square_finder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          i_clock,
    input  logic          i_reset,
    square_finder_if.slave bus
);

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_busy;
    logic       r_done;
    logic       w_action_load;
    logic       w_action_step;
    logic       w_action_store;
    logic       w_flag_equal;

    always_comb begin
        w_state_next   = r_state;
        w_action_load  = 1'b0;
        w_action_step  = 1'b0;
        w_action_store = 1'b0;
        case (r_state)
            state_idle: begin
                if (bus.start) begin
                    w_action_load = 1'b1;
                    w_state_next  = state_run;
                end
            end
            state_run: begin
                if (w_flag_equal) begin
                    w_action_store = 1'b1;
                    w_state_next   = state_done;
                end else begin
                    w_action_step = 1'b1;
                end
            end
            state_done: w_state_next = state_idle;
            default:    w_state_next = state_idle;
        endcase
    end

    // busy/done registered from the next state so they line up with r_state
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= state_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == state_run) || (w_state_next == state_done);
            r_done  <= (w_state_next == state_done);
        end
    end

    square_path_data #(
        .WIDTH (WIDTH)
    ) u_path_data (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_action_load  (w_action_load),
        .i_action_step  (w_action_step),
        .i_action_store (w_action_store),
        .i_root         (bus.root),
        .o_flag_equal   (w_flag_equal),
        .o_square       (bus.square)
    );

    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
